pkt_meta_rewrite: RTL
=====================

// Module: pkt_meta_rewrite
// PURPOSE
//  Stage directly downstream of the stream parser. Buffers 134b packet beats until the parser
//  delivers that packet's 128b result meta. Rewrites the Ethernet MACs in the head beat from
//  the meta, or drops the packet, then streams it out under downstream backpressure.
//  Packets and metas are matched strictly in arrival order (one meta per packet).
// PARAMETERS
//  PKT_AW   9  log2 depth of the packet beat FIFO (512 x 134b)
//  META_AW  4  log2 depth of the meta FIFO (16 x 128b)
//  AF_MARGIN 32  free-entry threshold below which o_alm_full asserts
// PORTS
//  i_clk         in   1    clock
//  i_rst_n       in   1    reset, asynchronous, active-low
//  i_pkt_valid   in   1    packet beat valid (no ready; upstream honours o_alm_full)
//  i_pkt         in   134  [133:132] 01 head, 10 tail, 11 head+tail, 00 body; [131:128] valid; [127:0] data
//  i_meta_valid  in   1    parser meta valid, one pulse per packet
//  i_meta        in   128  [127:80] new DMAC, [79:32] new SMAC, [1] rewrite_en, [0] drop
//  o_pkt_valid   out  1    output beat valid
//  o_pkt         out  134  output beat, same format as i_pkt
//  i_ready       in   1    downstream accepts o_pkt when o_pkt_valid & i_ready
//  o_alm_full    out  1    packet FIFO free entries < AF_MARGIN, or meta FIFO full
//  o_err_ovf     out  1    sticky: write attempted into a full FIFO (beat or meta discarded)
//  o_drop_cnt    out  32   packets dropped by meta[0], wraps at 2^32
// BEHAVIOUR
//  - Reset values: o_pkt_valid=0, o_pkt=0, o_alm_full=0, o_err_ovf=0, o_drop_cnt=0. FSM=IDLE. FIFOs are emptied.
//  - Reset mid-packet aborts the packet. No partial tail is emitted after reset.
//  - Input: each i_pkt_valid beat is written to the packet FIFO. Each i_meta_valid is written to the meta FIFO.
//    A write to a full FIFO is discarded and sets o_err_ovf.
//  - FIFOs: read latency 1 (data valid the cycle after rd_en).
//  - Output: single skid-free output register. It is loaded when it is empty or when (o_pkt_valid & i_ready).
//    o_pkt/o_pkt_valid hold stable while o_pkt_valid & !i_ready.
//  - FSM:
//    IDLE:  when meta FIFO non-empty and packet FIFO non-empty, pop meta and the head beat -> HEAD.
//    HEAD:  latch meta.
//           drop=1: discard the beat -> DROP, or -> IDLE if the tag is 11; increment o_drop_cnt.
//           drop=0: emit the beat. If rewrite_en, data[127:80]=DMAC and data[79:32]=SMAC; other bits unchanged.
//           Go to BODY, or IDLE if the tag is 11.
//    BODY:  pop and emit beats unmodified while the output register can load and the FIFO is non-empty.
//           Tail emitted -> IDLE.
//    DROP:  pop and discard beats at 1 per cycle regardless of i_ready. Tail popped -> IDLE.
//  - Latency: packet head and meta both present in the FIFOs with the output free -> o_pkt_valid 2 cycles later.
//    Throughput is 1 beat/cycle inside a packet; 1 idle cycle between packets.
//  - The head beat is never emitted before its meta. A meta arriving before its packet waits in its FIFO.
//  - Packet FIFO empty mid-packet (BODY): insert bubbles (o_pkt_valid=0), no error.
//  - Simultaneous i_meta_valid and meta pop on a full meta FIFO: the write is accepted.
//    Same rule for the packet FIFO: full and popping in the same cycle -> write accepted.
//  - o_alm_full is registered, 1-cycle lag.
//  - o_drop_cnt: 32b unsigned, wraps 0xFFFFFFFF -> 0.
// STRUCTURE
//  - Shared header pkt_defines.vh: TAG_HEAD=2'b01, TAG_TAIL=2'b10, TAG_SINGLE=2'b11, TAG_BODY=2'b00.
//    Also in the header: DMAC/SMAC bit ranges, meta field positions, FSM state encodings.
//  - Sub-module: syncfifo (existing, parameterised width/depth), instantiated twice (134b and 128b).
//  - Top-level body: FSM, head rewrite mux, output register, counters.
// TESTING
//  1. Meta {DMAC=0x112233445566, SMAC=0xAABBCCDDEEFF, rewrite_en=1}, then a 4-beat packet, i_ready=1
//     -> 4 beats out; head [127:32] = 0x112233445566_AABBCCDDEEFF; beats 2-4 are bit-identical to input.
//  2. 4-beat packet first, meta 10 cycles later -> no output before the meta.
//     Head appears 2 cycles after the meta write completes; order preserved.
//  3. Two packets with metas {drop=1} then {rewrite_en=0}
//     -> packet 1 absent from output, o_drop_cnt=1; packet 2 emitted unmodified.
//  4. i_ready toggled 1010... during a 6-beat packet
//     -> o_pkt held stable while stalled; all 6 beats delivered in order, none duplicated.
//  5. Write 600 beats with no meta
//     -> o_alm_full=1 once free entries < 32; o_err_ovf=1 after beat 513; beats 513-600 discarded.
//  6. Assert i_rst_n=0 mid-packet during BODY
//     -> o_pkt_valid=0 immediately; FIFOs empty; a fresh packet+meta afterwards is processed normally.

Source files
------------

// File: rtl/pkt_meta_rewrite_pkg.sv
// Shared types and constants for the packet meta rewrite stage.
package pkt_meta_rewrite_pkg;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned VLD_W    = 4;
    localparam int unsigned TAG_W    = 2;
    localparam int unsigned BEAT_W   = TAG_W + VLD_W + DATA_W;
    localparam int unsigned META_W   = 128;
    localparam int unsigned MAC_W    = 48;
    localparam int unsigned DMAC_LSB = 80;
    localparam int unsigned SMAC_LSB = 32;
    localparam int unsigned RSVD_W   = META_W - 2 * MAC_W - 2;
    localparam int unsigned CNT_W    = 32;

    // Beat position tags carried in the top two bits of every beat
    typedef enum logic [TAG_W-1:0] {
        TAG_BODY   = 2'b00,
        TAG_HEAD   = 2'b01,
        TAG_TAIL   = 2'b10,
        TAG_SINGLE = 2'b11
    } tag_e;

    typedef struct packed {
        tag_e              tag;
        logic [VLD_W-1:0]  vld;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [MAC_W-1:0]  dmac;
        logic [MAC_W-1:0]  smac;
        logic [RSVD_W-1:0] rsvd;
        logic              rewrite_en;
        logic              drop;
    } meta_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_BODY = 2'b10,
        ST_DROP = 2'b11
    } state_t;

    // True for the beat that closes a packet
    function automatic logic is_last(input tag_e tag);
        return (tag == TAG_TAIL) || (tag == TAG_SINGLE);
    endfunction

    // Head beat with both MACs replaced when the meta asks for it
    function automatic beat_t rewrite_head(input beat_t b, input meta_t m);
        beat_t r;
        r = b;
        if (m.rewrite_en) begin
            r.data[DMAC_LSB +: MAC_W] = m.dmac;
            r.data[SMAC_LSB +: MAC_W] = m.smac;
        end
        return r;
    endfunction

endpackage

// File: rtl/pkt_meta_rewrite_syncfifo.sv
// Single-clock FIFO with registered read data (valid the cycle after rd_en).
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module pkt_meta_rewrite_syncfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty_c,
    output logic             full_c,
    output logic             ovf_c,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_c = (count == CW'(0));
    assign full_c  = (count == CW'(DEPTH));
    assign rd_ok   = rd_en && !empty_c;
    assign wr_ok   = wr_en && (!full_c || rd_ok);
    assign ovf_c   = wr_en && !wr_ok;

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_meta_rewrite.sv
// Buffers packet beats until the matching parser meta arrives, then rewrites
// the head MACs or drops the packet, and streams it out under backpressure.
module pkt_meta_rewrite
    import pkt_meta_rewrite_pkg::*;
#(
    parameter int unsigned PKT_AW    = 9,
    parameter int unsigned META_AW   = 4,
    parameter int unsigned AF_MARGIN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pkt_valid,
    input  logic [BEAT_W-1:0] i_pkt,
    input  logic              i_meta_valid,
    input  logic [META_W-1:0] i_meta,
    output logic              o_pkt_valid,
    output logic [BEAT_W-1:0] o_pkt,
    input  logic              i_ready,
    output logic              o_alm_full,
    output logic              o_err_ovf,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    localparam int unsigned PKT_DEPTH = 2 ** PKT_AW;
    localparam int unsigned PKT_CW    = PKT_AW + 1;

    logic [BEAT_W-1:0] pkt_rd_raw;
    logic [META_W-1:0] meta_rd_raw;
    beat_t             pkt_rd;
    meta_t             meta_rd;
    logic              pkt_empty_c;
    logic              pkt_full_c;
    logic              pkt_ovf_c;
    logic [PKT_AW:0]   pkt_count;
    logic [PKT_AW:0]   pkt_free_c;
    logic              meta_empty_c;
    logic              meta_full_c;
    logic              meta_ovf_c;
    logic [META_AW:0]  meta_count;

    state_t            state;
    state_t            state_n;
    logic              beat_vld;
    logic              beat_vld_n;
    logic              pkt_pop;
    logic              meta_pop;
    logic              consume;
    logic              out_load;
    beat_t             out_data;
    logic              drop_inc;
    logic              out_free;
    logic              last;
    logic              unused_meta;

    pkt_meta_rewrite_syncfifo #(
        .WIDTH (BEAT_W),
        .AW    (PKT_AW)
    ) u_pkt_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (i_pkt_valid),
        .wr_data (i_pkt),
        .rd_en   (pkt_pop),
        .rd_data (pkt_rd_raw),
        .empty_c (pkt_empty_c),
        .full_c  (pkt_full_c),
        .ovf_c   (pkt_ovf_c),
        .count   (pkt_count)
    );

    pkt_meta_rewrite_syncfifo #(
        .WIDTH (META_W),
        .AW    (META_AW)
    ) u_meta_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (i_meta_valid),
        .wr_data (i_meta),
        .rd_en   (meta_pop),
        .rd_data (meta_rd_raw),
        .empty_c (meta_empty_c),
        .full_c  (meta_full_c),
        .ovf_c   (meta_ovf_c),
        .count   (meta_count)
    );

    assign pkt_rd      = beat_t'(pkt_rd_raw);
    assign meta_rd     = meta_t'(meta_rd_raw);
    assign pkt_free_c  = PKT_CW'(PKT_DEPTH) - pkt_count;
    assign out_free    = !o_pkt_valid || i_ready;
    assign last        = is_last(pkt_rd.tag);
    assign unused_meta = ^{meta_rd.rsvd, meta_count, pkt_full_c};

    // Packet state register and popped-beat-present flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            beat_vld <= 1'b0;
        end else begin
            state    <= state_n;
            beat_vld <= beat_vld_n;
        end
    end

    // Next state, FIFO pops and output-register load.
    // beat_vld marks a popped beat sitting on the packet FIFO read port;
    // the next pop is only issued once that beat is taken and is not a tail,
    // so the following packet's head is never pulled early.
    always_comb begin
        state_n  = state;
        pkt_pop  = 1'b0;
        meta_pop = 1'b0;
        consume  = 1'b0;
        out_load = 1'b0;
        out_data = pkt_rd;
        drop_inc = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!meta_empty_c && !pkt_empty_c) begin
                    meta_pop = 1'b1;
                    pkt_pop  = 1'b1;
                    state_n  = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (meta_rd.drop) begin
                    consume  = 1'b1;
                    drop_inc = 1'b1;
                    state_n  = last ? ST_IDLE : ST_DROP;
                end else if (out_free) begin
                    consume  = 1'b1;
                    out_load = 1'b1;
                    out_data = rewrite_head(pkt_rd, meta_rd);
                    state_n  = last ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                if (beat_vld && out_free) begin
                    consume  = 1'b1;
                    out_load = 1'b1;
                    if (last) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (beat_vld) begin
                    consume = 1'b1;
                    if (last) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if ((state != ST_IDLE) && !pkt_empty_c && (!beat_vld || (consume && !last))) begin
            pkt_pop = 1'b1;
        end

        if (pkt_pop) begin
            beat_vld_n = 1'b1;
        end else if (consume) begin
            beat_vld_n = 1'b0;
        end else begin
            beat_vld_n = beat_vld;
        end
    end

    // Output register: loads when empty or being accepted, holds while stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_valid <= 1'b0;
            o_pkt       <= '0;
        end else if (out_load) begin
            o_pkt_valid <= 1'b1;
            o_pkt       <= out_data;
        end else if (i_ready) begin
            o_pkt_valid <= 1'b0;
        end
    end

    // Status: almost-full flag, sticky overflow, dropped-packet counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alm_full <= 1'b0;
            o_err_ovf  <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            o_alm_full <= (pkt_free_c < PKT_CW'(AF_MARGIN)) || meta_full_c;
            o_err_ovf  <= o_err_ovf || pkt_ovf_c || meta_ovf_c;
            if (drop_inc) begin
                o_drop_cnt <= o_drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule
